boruss_mem_arbiter: RTL and testbench

//  Shares the single data port of boruss_memory_controller between two requesters:

---
 rtl/boruss_mem_arbiter_pkg.sv | 20 ++
 rtl/boruss_rr_picker.sv | 23 ++
 rtl/boruss_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_boruss_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boruss_mem_arbiter_pkg.sv
// Shared definitions for the boruss memory-port arbiter: FSM encodings,
// requester port indices and the conflict counter ceiling.
package boruss_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // One-hot ownership vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        port_onehot = (port == PORT_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/boruss_rr_picker.sv
// Combinational two-way picker. A tie goes to the port that did not win
// last time, or always to port 0 when fixed priority is selected.
module boruss_rr_picker
    import boruss_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed,
    output logic [1:0] pick
);

    // Winner selection; last_grant is the index of the previous winner.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (fixed || last_grant == PORT_DBG) ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/boruss_mem_arbiter.sv
// Arbitrates the memory controller data port between the CPU (port 0) and
// the debug/program loader (port 1). One transaction in flight at a time:
// IDLE picks and captures a command, ISSUE strobes the memory for one cycle,
// WAIT covers the read latency, RESP pulses the winner's ack.
module boruss_mem_arbiter
    import boruss_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_sel,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_sel,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mem_map_select,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [7:0]        conflict_cnt
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_we;
    logic              r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [7:0]        r_conflict;

    logic [1:0] w_req;
    logic [1:0] w_pick;
    logic [1:0] w_owner_oh;
    logic       w_issue;
    logic       w_resp;
    logic       w_busy;
    logic       w_wait;

    assign w_req      = {p1_req, p0_req};
    assign w_owner_oh = port_onehot(r_owner);
    assign w_issue    = (r_state == ST_ISSUE);
    assign w_resp     = (r_state == ST_RESP);
    assign w_busy     = (r_state != ST_IDLE);

    boruss_rr_picker u_pick (
        .req        (w_req),
        .last_grant (r_last_grant),
        .fixed      (FIXED_PRIO != 0),
        .pick       (w_pick)
    );

    // FSM, command capture at grant, read-latency countdown and rdata capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= PORT_CPU;
            r_last_grant <= PORT_DBG;
            r_we         <= 1'b0;
            r_sel        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat        <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner      <= w_pick[1];
                        r_last_grant <= w_pick[1];
                        r_we         <= w_pick[1] ? p1_we    : p0_we;
                        r_sel        <= w_pick[1] ? p1_sel   : p0_sel;
                        r_addr       <= w_pick[1] ? p1_addr  : p0_addr;
                        r_wdata      <= w_pick[1] ? p1_wdata : p0_wdata;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_lat   <= LAT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_lat == '0) begin
                        if (r_owner == PORT_DBG) r_rdata1 <= mem_data_out;
                        else                     r_rdata0 <= mem_data_out;
                        r_state <= ST_RESP;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A cycle counts as a conflict when some request is high but not owning
    // (or being picked for) the port.
    assign w_wait = w_busy ? |(w_req & ~w_owner_oh) : |(w_req & ~w_pick);

    // Saturating conflict counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_conflict <= '0;
        else if (w_wait && r_conflict != CNT_MAX)
            r_conflict <= r_conflict + 8'd1;
    end

    assign mem_we         = w_issue & r_we;
    assign mem_re         = w_issue & ~r_we;
    assign mem_addr       = r_addr;
    assign mem_map_select = r_sel;
    assign mem_data_in    = (w_issue & r_we) ? r_wdata : '0;

    assign grant        = w_busy ? w_owner_oh : 2'b00;
    assign busy         = w_busy;
    assign conflict_cnt = r_conflict;

    assign p0_ack   = w_resp & (r_owner == PORT_CPU);
    assign p1_ack   = w_resp & (r_owner == PORT_DBG);
    assign p0_rdata = r_rdata0;
    assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_boruss_mem_arbiter.sv
// Bench for boruss_mem_arbiter: two instances (round-robin with latency 1,
// fixed priority with latency 3) driven by randomized requesters, a memory
// stub, and a transaction-timing reference model checked every cycle.
module tb_boruss_mem_arbiter;

    localparam int LAT [2] = '{1, 3};
    localparam int FP  [2] = '{0, 1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       req0 [2], req1 [2], we0 [2], we1 [2], sel0 [2], sel1 [2];
    logic [7:0] addr0 [2], addr1 [2], wd0 [2], wd1 [2];
    logic       ack0 [2], ack1 [2];
    logic [7:0] rd0 [2], rd1 [2];
    logic [7:0] m_addr [2], m_din [2], m_dout [2];
    logic       m_we [2], m_re [2], m_sel [2];
    logic [1:0] grant [2];
    logic       busy [2];
    logic [7:0] ccnt [2];

    // memory stub state
    logic [7:0] rmem [2][512];
    bit         wflag [2][512];
    logic [7:0] dpipe [2][3];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        boruss_mem_arbiter #(
            .ADDR_W(8), .DATA_W(8), .RD_LATENCY(LAT[g]), .FIXED_PRIO(FP[g])
        ) u_dut (
            .clk(clk), .reset(reset),
            .p0_req(req0[g]), .p0_we(we0[g]), .p0_sel(sel0[g]), .p0_addr(addr0[g]),
            .p0_wdata(wd0[g]), .p0_ack(ack0[g]), .p0_rdata(rd0[g]),
            .p1_req(req1[g]), .p1_we(we1[g]), .p1_sel(sel1[g]), .p1_addr(addr1[g]),
            .p1_wdata(wd1[g]), .p1_ack(ack1[g]), .p1_rdata(rd1[g]),
            .mem_addr(m_addr[g]), .mem_data_in(m_din[g]), .mem_we(m_we[g]),
            .mem_re(m_re[g]), .mem_map_select(m_sel[g]), .mem_data_out(m_dout[g]),
            .grant(grant[g]), .busy(busy[g]), .conflict_cnt(ccnt[g])
        );
    end

    function automatic logic [7:0] init_val(input logic [8:0] ix);
        return ix[7:0] ^ 8'h5A ^ {ix[8], 7'd0};
    endfunction

    // Memory stub: write on mem_we, read data appears exactly LAT cycles
    // after mem_re; junk otherwise so a mistimed sample is caught.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_we[k]) begin
                rmem[k][{m_sel[k], m_addr[k]}]  <= m_din[k];
                wflag[k][{m_sel[k], m_addr[k]}] <= 1'b1;
            end
            dpipe[k][0] <= m_re[k] ? (wflag[k][{m_sel[k], m_addr[k]}] ?
                           rmem[k][{m_sel[k], m_addr[k]}] : init_val({m_sel[k], m_addr[k]}))
                           : 8'($urandom);
            dpipe[k][1] <= dpipe[k][0];
            dpipe[k][2] <= dpipe[k][1];
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) m_dout[k] = dpipe[k][LAT[k]-1];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic string tg(input int k, input string n);
        return $sformatf("u%0d_%s", k, n);
    endfunction

    // Reference model: a transaction granted at cycle t issues at t+1,
    // acks at t+2 (+LAT for reads) and frees the port the cycle after.
    int         t;
    int         free_at [2], iss_at [2], ack_at [2], cnt [2], p1acks [2];
    logic       own [2], cwe [2], csel [2], last [2];
    logic [7:0] caddr [2], cwd [2], exp_rd [2];
    logic [7:0] rdh [2][2];
    logic [7:0] mmem [2][512];
    logic       pw_v [2];
    logic [8:0] pw_ix [2];
    logic [7:0] pw_d [2];
    logic       aseen [2][2];
    int         mode;

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            free_at[k] = 0; iss_at[k] = -1; ack_at[k] = -1; cnt[k] = 0;
            own[k] = 0; cwe[k] = 0; csel[k] = 0; last[k] = 1;
            caddr[k] = 0; cwd[k] = 0; exp_rd[k] = 0;
            rdh[k][0] = 0; rdh[k][1] = 0; pw_v[k] = 0;
            aseen[k][0] = 0; aseen[k][1] = 0;
        end
    endtask

    task automatic chk_zero(input int k);
        chk(tg(k, "rst_busy"), busy[k], 0);
        chk(tg(k, "rst_grant"), grant[k], 0);
        chk(tg(k, "rst_we"), m_we[k], 0);
        chk(tg(k, "rst_re"), m_re[k], 0);
        chk(tg(k, "rst_addr"), m_addr[k], 0);
        chk(tg(k, "rst_din"), m_din[k], 0);
        chk(tg(k, "rst_sel"), m_sel[k], 0);
        chk(tg(k, "rst_ack0"), ack0[k], 0);
        chk(tg(k, "rst_ack1"), ack1[k], 0);
        chk(tg(k, "rst_rd0"), rd0[k], 0);
        chk(tg(k, "rst_rd1"), rd1[k], 0);
        chk(tg(k, "rst_cnt"), ccnt[k], 0);
    endtask

    task automatic check_and_model();
        logic bsy, iss, ea0, ea1, wt, w;
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
            if (pw_v[k]) begin
                mmem[k][pw_ix[k]] = pw_d[k];
                pw_v[k] = 0;
            end
            bsy = (t < free_at[k]);
            r   = {req1[k], req0[k]};
            iss = bsy && (t == iss_at[k]);
            ea0 = bsy && (t == ack_at[k]) && !own[k];
            ea1 = bsy && (t == ack_at[k]) && own[k];
            if (bsy && t == ack_at[k] && !cwe[k]) rdh[k][own[k]] = exp_rd[k];
            chk(tg(k, "busy"), busy[k], bsy);
            chk(tg(k, "grant"), grant[k], bsy ? (own[k] ? 2'b10 : 2'b01) : 2'b00);
            chk(tg(k, "mem_we"), m_we[k], iss && cwe[k]);
            chk(tg(k, "mem_re"), m_re[k], iss && !cwe[k]);
            chk(tg(k, "mem_addr"), m_addr[k], caddr[k]);
            chk(tg(k, "mem_sel"), m_sel[k], csel[k]);
            chk(tg(k, "mem_din"), m_din[k], (iss && cwe[k]) ? cwd[k] : 8'h00);
            chk(tg(k, "ack0"), ack0[k], ea0);
            chk(tg(k, "ack1"), ack1[k], ea1);
            chk(tg(k, "rdata0"), rd0[k], rdh[k][0]);
            chk(tg(k, "rdata1"), rd1[k], rdh[k][1]);
            chk(tg(k, "conflict"), ccnt[k], cnt[k]);
            aseen[k][0] = ea0;
            aseen[k][1] = ea1;
            if (ack1[k]) p1acks[k]++;
            if (iss && cwe[k]) begin
                pw_v[k] = 1; pw_ix[k] = {csel[k], caddr[k]}; pw_d[k] = cwd[k];
            end
            wt = bsy ? (own[k] ? r[0] : r[1]) : (r == 2'b11);
            if (wt && cnt[k] < 255) cnt[k]++;
            if (!bsy && r != 2'b00) begin
                if (r == 2'b01)      w = 0;
                else if (r == 2'b10) w = 1;
                else                 w = (FP[k] != 0) ? 1'b0 : !last[k];
                last[k]  = w;
                own[k]   = w;
                cwe[k]   = w ? we1[k] : we0[k];
                csel[k]  = w ? sel1[k] : sel0[k];
                caddr[k] = w ? addr1[k] : addr0[k];
                cwd[k]   = w ? wd1[k] : wd0[k];
                iss_at[k]  = t + 1;
                ack_at[k]  = t + 2 + (cwe[k] ? 0 : LAT[k]);
                free_at[k] = ack_at[k] + 1;
                if (!cwe[k]) exp_rd[k] = mmem[k][{csel[k], caddr[k]}];
            end
        end
        t++;
    endtask

    task automatic set_req(input int k, input int p, input logic v);
        if (p == 0) req0[k] = v; else req1[k] = v;
    endtask

    task automatic new_cmd(input int k, input int p);
        logic       w, s;
        logic [7:0] a, d;
        w = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        a = 8'($urandom_range(0, 15));
        d = 8'($urandom);
        if (p == 0) begin
            req0[k] = 1; we0[k] = w; sel0[k] = s; addr0[k] = a; wd0[k] = d;
        end else begin
            req1[k] = 1; we1[k] = w; sel1[k] = s; addr1[k] = a; wd1[k] = d;
        end
    endtask

    // Requester behaviour: 0 = random traffic, 1 = both ports always
    // requesting, 2 = drop request after ack only.
    task automatic drive();
        logic rq, ak;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                rq = (p == 0) ? req0[k] : req1[k];
                ak = aseen[k][p];
                case (mode)
                    0: begin
                        if (rq) begin
                            if (ak) begin
                                if ($urandom_range(0, 1) == 0) new_cmd(k, p);
                                else set_req(k, p, 0);
                            end else if ($urandom_range(0, 15) == 0) new_cmd(k, p);
                            else if ($urandom_range(0, 63) == 0) set_req(k, p, 0);
                        end else if ($urandom_range(0, 3) == 0) new_cmd(k, p);
                    end
                    1: if (ak || !rq) new_cmd(k, p);
                    default: if (ak) set_req(k, p, 0);
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        check_and_model();
    endtask

    bit found;
    int tt;

    initial begin
        t = 0;
        mode = 2;
        reset_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 512; i++) mmem[k][i] = init_val(9'(i));
            req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0; sel0[k] = 0; sel1[k] = 0;
            addr0[k] = 0; addr1[k] = 0; wd0[k] = 0; wd1[k] = 0;
            p1acks[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 for (int k = 0; k < 2; k++) chk_zero(k);

        // p0 write 0x10 <= A5 to RAM, then p1 reads it back
        for (int k = 0; k < 2; k++) begin
            req0[k] = 1; we0[k] = 1; sel0[k] = 1; addr0[k] = 8'h10; wd0[k] = 8'hA5;
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check_and_model();
        repeat (12) cycle();
        @(posedge clk);
        #1 for (int k = 0; k < 2; k++) begin
            req1[k] = 1; we1[k] = 0; sel1[k] = 1; addr1[k] = 8'h10; wd1[k] = 8'h00;
        end
        @(negedge clk);
        check_and_model();
        repeat (10) cycle();
        for (int k = 0; k < 2; k++) chk(tg(k, "readback"), rd1[k], 8'hA5);

        // random traffic, conflict counter climbs from zero
        mode = 0;
        repeat (1200) cycle();

        // both ports hammering: RR alternates, fixed priority starves port 1
        mode = 1;
        for (int k = 0; k < 2; k++) p1acks[k] = 0;
        repeat (400) cycle();
        chk("u1_p1_starved", p1acks[1], 0);
        chk("u1_cnt_sat", ccnt[1], 8'hFF);
        chk("u0_p1_served", p1acks[0] > 0, 1);

        // reset during a read WAIT on the latency-3 instance
        mode = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle();
            tt = t - 1;
            if (tt < free_at[1] && !cwe[1] && tt > iss_at[1] && tt < ack_at[1]) found = 1;
        end
        chk("rst_wait_found", found, 1);
        #2 reset = 1'b0;
        #1 for (int k = 0; k < 2; k++) chk_zero(k);
        reset_model();
        for (int k = 0; k < 2; k++) begin
            new_cmd(k, 0);
            new_cmd(k, 1);
        end
        @(posedge clk);
        #1 for (int k = 0; k < 2; k++) begin
            chk(tg(k, "rst_noack0"), ack0[k], 0);
            chk(tg(k, "rst_noack1"), ack1[k], 0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check_and_model();
        cycle();
        for (int k = 0; k < 2; k++) chk(tg(k, "rst_tie_p0"), grant[k], 2'b01);
        repeat (600) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
